// File: rtl/m2_bus_capture_pkg.sv
// rtl/m2_bus_capture_pkg.sv - shared bus-capture state encoding, timing defaults and helpers
package m2_bus_capture_pkg;

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_HIGH   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_STUCK  = 3'd4
  } cap_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_HIGH    = 4;
  localparam int DEF_ADDR_SETTLE = 2;
  localparam int DEF_MAX_HIGH    = 255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/m2_bus_capture_if.sv
// rtl/m2_bus_capture_if.sv - raw console CPU bus in, clean captured bus and diagnostics out
interface m2_bus_capture_if;

  logic        m2_raw;
  logic [15:0] cpu_addr_raw;
  logic [7:0]  cpu_dat_raw;
  logic        cpu_rw_raw;
  logic        romsel_n_raw;

  logic [15:0] bus_addr;
  logic [7:0]  bus_dat;
  logic        bus_romsel_n;
  logic        wr_stb;
  logic        rd_stb;
  logic        m2_stuck;
  logic [7:0]  glitch_cnt;

  // master: the console side driving the raw bus and observing captured results
  modport master (
    output m2_raw, cpu_addr_raw, cpu_dat_raw, cpu_rw_raw, romsel_n_raw,
    input  bus_addr, bus_dat, bus_romsel_n, wr_stb, rd_stb, m2_stuck, glitch_cnt
  );

  modport slave (
    input  m2_raw, cpu_addr_raw, cpu_dat_raw, cpu_rw_raw, romsel_n_raw,
    output bus_addr, bus_dat, bus_romsel_n, wr_stb, rd_stb, m2_stuck, glitch_cnt
  );

endinterface

// File: rtl/m2_bus_capture_bus_sync_vec.sv
// rtl/m2_bus_capture_bus_sync_vec.sv - STAGES-deep flop chain synchronizer for a WIDTH-bit bus
module bus_sync_vec #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/m2_bus_capture.sv
// rtl/m2_bus_capture.sv - resamples the console CPU bus and emits one qualified
// read/write strobe per valid M2 high phase, flagging glitched and stuck M2
module m2_bus_capture
  import m2_bus_capture_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_HIGH    = DEF_MIN_HIGH,
  parameter int ADDR_SETTLE = DEF_ADDR_SETTLE,
  parameter int MAX_HIGH    = DEF_MAX_HIGH
) (
  input  logic               clk,
  input  logic               rst,
  m2_bus_capture_if.slave    bus
);

  localparam logic [7:0] MIN_HIGH_C = 8'(MIN_HIGH);
  localparam logic [7:0] SETTLE_C   = 8'(ADDR_SETTLE);
  localparam logic [7:0] MAX_HIGH_C = 8'(MAX_HIGH);

  logic [2:0]  ctrl_s;
  logic [15:0] addr_s;
  logic [7:0]  dat_s;
  logic [7:0]  dat_d;
  logic        m2_s, rw_s, romsel_s;

  bus_sync_vec #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync_ctrl (
    .clk (clk), .rst (rst),
    .d   ({bus.m2_raw, bus.cpu_rw_raw, bus.romsel_n_raw}),
    .q   (ctrl_s)
  );

  bus_sync_vec #(.WIDTH(16), .STAGES(SYNC_STAGES)) u_sync_addr (
    .clk (clk), .rst (rst), .d (bus.cpu_addr_raw), .q (addr_s)
  );

  bus_sync_vec #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_dat (
    .clk (clk), .rst (rst), .d (bus.cpu_dat_raw), .q (dat_s)
  );

  assign m2_s     = ctrl_s[2];
  assign rw_s     = ctrl_s[1];
  assign romsel_s = ctrl_s[0];

  // Synchronizer outputs are only meaningful once the chain has refilled after
  // reset; ARM must not mistake the cleared flops for a low M2.
  logic [SYNC_STAGES-1:0] prime;
  logic                   primed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prime <= '0;
    else     prime <= {prime[SYNC_STAGES-2:0], 1'b1};
  end

  assign primed = prime[SYNC_STAGES-1];

  cap_state_t  state, state_nxt;
  logic [7:0]  hi_cnt, hi_cnt_nxt;
  logic        commit, glitch, latch_addr, late;

  always_comb begin
    state_nxt  = state;
    hi_cnt_nxt = hi_cnt;
    commit     = 1'b0;
    glitch     = 1'b0;
    case (state)
      ST_ARM: begin
        if (primed && !m2_s) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (m2_s) begin
          state_nxt  = ST_HIGH;
          hi_cnt_nxt = 8'd1;
        end
      end
      ST_HIGH: begin
        if (!m2_s) begin
          if (hi_cnt >= MIN_HIGH_C) begin
            commit    = 1'b1;
            state_nxt = ST_COMMIT;
          end else begin
            glitch    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (hi_cnt >= MAX_HIGH_C) begin
          // counter is saturated: this clk would be high count MAX_HIGH+1
          state_nxt = ST_STUCK;
        end else begin
          hi_cnt_nxt = sat_inc8(hi_cnt);
        end
      end
      ST_COMMIT: begin
        if (m2_s) begin
          state_nxt  = ST_HIGH;
          hi_cnt_nxt = 8'd1;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_STUCK: begin
        if (!m2_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_ARM;
      hi_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      hi_cnt <= hi_cnt_nxt;
    end
  end

  logic [15:0] addr_hold;
  logic [7:0]  dat_hold;
  logic        rw_hold, romsel_hold;
  logic [15:0] c_addr;
  logic        c_rw, c_romsel;

  assign latch_addr = (state == ST_HIGH) && (hi_cnt == SETTLE_C);
  // Only reachable when MIN_HIGH <= ADDR_SETTLE: the settle point never came
  assign late     = (hi_cnt <= SETTLE_C);
  assign c_addr   = late ? addr_s   : addr_hold;
  assign c_rw     = late ? rw_s     : rw_hold;
  assign c_romsel = late ? romsel_s : romsel_hold;

  logic [15:0] bus_addr_q;
  logic [7:0]  bus_dat_q;
  logic        bus_romsel_q, wr_stb_q, rd_stb_q, m2_stuck_q;
  logic [7:0]  glitch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_d        <= 8'd0;
      dat_hold     <= 8'd0;
      addr_hold    <= 16'd0;
      rw_hold      <= 1'b0;
      romsel_hold  <= 1'b1;
      bus_addr_q   <= 16'd0;
      bus_dat_q    <= 8'd0;
      bus_romsel_q <= 1'b1;
      wr_stb_q     <= 1'b0;
      rd_stb_q     <= 1'b0;
      m2_stuck_q   <= 1'b0;
      glitch_cnt_q <= 8'd0;
    end else begin
      dat_d <= dat_s;
      if (state == ST_HIGH) dat_hold <= dat_d;
      if (latch_addr) begin
        addr_hold   <= addr_s;
        rw_hold     <= rw_s;
        romsel_hold <= romsel_s;
      end
      // outputs register on the HIGH->COMMIT edge, so they are valid during COMMIT
      if (commit) begin
        bus_addr_q   <= c_addr;
        bus_dat_q    <= dat_hold;
        bus_romsel_q <= c_romsel;
      end
      wr_stb_q   <= commit && !c_rw;
      rd_stb_q   <= commit &&  c_rw;
      m2_stuck_q <= (state_nxt == ST_STUCK);
      if (glitch) glitch_cnt_q <= sat_inc8(glitch_cnt_q);
    end
  end

  assign bus.bus_addr     = bus_addr_q;
  assign bus.bus_dat      = bus_dat_q;
  assign bus.bus_romsel_n = bus_romsel_q;
  assign bus.wr_stb       = wr_stb_q;
  assign bus.rd_stb       = rd_stb_q;
  assign bus.m2_stuck     = m2_stuck_q;
  assign bus.glitch_cnt   = glitch_cnt_q;

endmodule

// File: tb/tb_m2_bus_capture.sv
// tb/tb_m2_bus_capture.sv - directed bench for m2_bus_capture
module tb_m2_bus_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  m2_bus_capture_if bus_if ();

  m2_bus_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int viol   = 0;
  logic wr_prev = 1'b0;
  logic rd_prev = 1'b0;
  logic [7:0] wr_dat_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m2, input logic [15:0] a, input logic [7:0] d,
                       input logic rw, input logic rs);
    bus_if.m2_raw       = m2;
    bus_if.cpu_addr_raw = a;
    bus_if.cpu_dat_raw  = d;
    bus_if.cpu_rw_raw   = rw;
    bus_if.romsel_n_raw = rs;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                           input logic rs, input int hi, input int lo);
    drive(1'b1, a, d, rw, rs);
    repeat (hi) tick();
    bus_if.m2_raw = 1'b0;
    repeat (lo) tick();
  endtask

  always @(negedge clk) begin
    if (bus_if.wr_stb) begin
      wr_cnt++;
      wr_dat_q.push_back(bus_if.bus_dat);
    end
    if (bus_if.rd_stb) rd_cnt++;
    if (bus_if.wr_stb && bus_if.rd_stb) viol++;
    if ((bus_if.wr_stb && wr_prev) || (bus_if.rd_stb && rd_prev)) viol++;
    wr_prev = bus_if.wr_stb;
    rd_prev = bus_if.rd_stb;
  end

  initial begin
    int w0, r0;
    drive(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_addr", 32'(bus_if.bus_addr), 32'h0);
    chk("rst_dat", 32'(bus_if.bus_dat), 32'h0);
    chk("rst_romsel", 32'(bus_if.bus_romsel_n), 32'h1);
    chk("rst_stb", {30'd0, bus_if.wr_stb, bus_if.rd_stb}, 32'h0);
    chk("rst_stuck", 32'(bus_if.m2_stuck), 32'h0);
    chk("rst_glitch", 32'(bus_if.glitch_cnt), 32'h0);

    // reset released mid-cycle: that cycle must not strobe
    rst = 1'b0;
    repeat (10) tick();
    bus_if.m2_raw = 1'b0;
    repeat (6) tick();
    chk("arm_nostb", 32'(wr_cnt + rd_cnt), 32'h0);

    // write with exact latency from raw fall
    w0 = wr_cnt;
    drive(1'b1, 16'hA000, 8'h1E, 1'b0, 1'b1);
    repeat (12) tick();
    bus_if.m2_raw = 1'b0;
    tick();
    chk("wr_lat1", 32'(bus_if.wr_stb), 32'h0);
    tick();
    chk("wr_lat2", 32'(bus_if.wr_stb), 32'h0);
    tick();
    chk("wr_lat3", 32'(bus_if.wr_stb), 32'h1);
    chk("wr_addr", 32'(bus_if.bus_addr), 32'hA000);
    chk("wr_dat", 32'(bus_if.bus_dat), 32'h1E);
    tick();
    chk("wr_pulse", 32'(bus_if.wr_stb), 32'h0);
    repeat (6) tick();
    chk("wr_count", 32'(wr_cnt - w0), 32'h1);

    // short glitch is rejected and outputs hold
    w0 = wr_cnt;
    cpu_cycle(16'h1234, 8'h77, 1'b0, 1'b1, 2, 8);
    chk("gl_nostb", 32'(wr_cnt - w0), 32'h0);
    chk("gl_cnt", 32'(bus_if.glitch_cnt), 32'h1);
    chk("gl_addr", 32'(bus_if.bus_addr), 32'hA000);
    chk("gl_dat", 32'(bus_if.bus_dat), 32'h1E);

    // read cycle in ROM space
    w0 = wr_cnt;
    r0 = rd_cnt;
    cpu_cycle(16'h8001, 8'h55, 1'b1, 1'b0, 12, 8);
    chk("rd_count", 32'(rd_cnt - r0), 32'h1);
    chk("rd_nowr", 32'(wr_cnt - w0), 32'h0);
    chk("rd_addr", 32'(bus_if.bus_addr), 32'h8001);
    chk("rd_romsel", 32'(bus_if.bus_romsel_n), 32'h0);

    // stuck M2
    w0 = wr_cnt;
    r0 = rd_cnt;
    drive(1'b1, 16'hC000, 8'h99, 1'b0, 1'b1);
    repeat (200) tick();
    chk("stuck_early", 32'(bus_if.m2_stuck), 32'h0);
    repeat (80) tick();
    chk("stuck_set", 32'(bus_if.m2_stuck), 32'h1);
    repeat (20) tick();
    bus_if.m2_raw = 1'b0;
    repeat (8) tick();
    chk("stuck_clr", 32'(bus_if.m2_stuck), 32'h0);
    chk("stuck_nostb", 32'(wr_cnt + rd_cnt - w0 - r0), 32'h0);
    cpu_cycle(16'hC000, 8'h5A, 1'b0, 1'b1, 12, 8);
    chk("post_stuck_wr", 32'(wr_cnt - w0), 32'h1);
    chk("post_stuck_dat", 32'(bus_if.bus_dat), 32'h5A);

    // back-to-back writes with 1-clk low gaps
    w0 = wr_cnt;
    wr_dat_q.delete();
    for (int i = 1; i <= 4; i++) cpu_cycle(16'hE000, 8'(i), 1'b0, 1'b1, 5, 1);
    repeat (8) tick();
    chk("b2b_count", 32'(wr_cnt - w0), 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_dat_q.size()) chk($sformatf("b2b_dat%0d", i), 32'(wr_dat_q[i]), 32'(i + 1));
      else chk($sformatf("b2b_dat%0d_missing", i), 32'hFFFF_FFFF, 32'(i + 1));
    end
    chk("b2b_addr", 32'(bus_if.bus_addr), 32'hE000);

    chk("stb_rules", 32'(viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m2_bus_capture.md
Name: m2_bus_capture

Overview:
- Front-end stage ahead of every mapper register file.
- Resamples the asynchronous console CPU bus (M2, address, data, R/W, /ROMSEL) into the FPGA system clock domain.
- Qualifies each M2 high phase and emits exactly one clean single-cycle write or read strobe per valid CPU cycle, with stable address/data. Mapper register banks (PRG/CHR bank regs, mirroring/mode regs) consume these instead of clocking on raw M2 edges.
- Also flags glitched and stuck M2 for diagnostics.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on all bus inputs (min 2).
- MIN_HIGH, 4, minimum synchronized M2-high clk count for a valid cycle.
- ADDR_SETTLE, 2, clk count after M2 rise at which the address/rw/romsel sample is taken.
- MAX_HIGH, 255, M2-high clk count above which M2 is declared stuck.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m2_raw  in  1  console M2, asynchronous
- cpu_addr_raw  in  16  CPU address, asynchronous
- cpu_dat_raw  in  8  CPU data bus, asynchronous
- cpu_rw_raw  in  1  1=read 0=write, asynchronous
- romsel_n_raw  in  1  /ROMSEL, asynchronous
- bus_addr  out  16  captured address, held until next strobe
- bus_dat  out  8  captured data, held until next strobe
- bus_romsel_n  out  1  captured /ROMSEL
- wr_stb  out  1  one-clk pulse: valid CPU write completed
- rd_stb  out  1  one-clk pulse: valid CPU read completed
- m2_stuck  out  1  level: M2 held high > MAX_HIGH
- glitch_cnt  out  8  saturating count of rejected short M2 pulses

Behaviour:
- Reset: asynchronous, active-high (rst). All outputs 0 except bus_romsel_n=1. State=ARM. Synchronizers cleared.
- Synchronization:
  - Every raw input passes through SYNC_STAGES flops.
  - Data additionally passes through one extra flop, so the last data sampled before the detected M2 fall is aligned to that fall.
- State machine:
  - ARM:
    - Waits for synced M2=0.
    - Then goes to IDLE.
    - Guarantees no strobe for a cycle already in progress when reset released.
  - IDLE:
    - Synced M2 rise → HIGH, hi_cnt=1.
  - HIGH:
    - hi_cnt increments each clk, saturating at 255.
    - At hi_cnt==ADDR_SETTLE: latch addr/rw/romsel into holding regs (not outputs).
    - Data holding reg reloads every clk while HIGH.
    - Exit on M2 fall:
      - hi_cnt>=MIN_HIGH → COMMIT.
      - Otherwise → IDLE, glitch_cnt+1 (saturates at 255), no strobe.
    - hi_cnt>MAX_HIGH → STUCK.
  - COMMIT (one clk):
    - Copy holding regs to bus_addr/bus_dat/bus_romsel_n.
    - Pulse wr_stb if rw=0, rd_stb if rw=1.
    - Next state IDLE.
    - A new M2 rise seen in this same clk is not lost: go directly to HIGH with hi_cnt=1.
  - STUCK:
    - m2_stuck=1, no strobes.
    - On M2 fall → IDLE, m2_stuck=0, no strobe for the stuck cycle.
- Latency: strobe asserted SYNC_STAGES+1 clk after raw M2 fall, ±1 clk metastability uncertainty.
- Strobe rules:
  - wr_stb and rd_stb are never both 1.
  - Each is never high for 2 consecutive clks.
  - At most one strobe per M2 high phase.
- Output stability: bus_addr/bus_dat/bus_romsel_n change only in the COMMIT clk.
- For reads, bus_dat reflects whatever was on the bus. Consumers ignore it on rd_stb. rd_stb is used for read-triggered side effects.
- If ADDR_SETTLE >= hi_cnt at fall (only when MIN_HIGH<=ADDR_SETTLE): the address is latched at the fall clk instead.

Decomposition:
- Shared package constants: bus-capture state encoding (ARM, IDLE, HIGH, COMMIT, STUCK) and the default MIN_HIGH/MAX_HIGH values, so mapper tops and the save-state controller agree on timing.
- One sub-module: bus_sync_vec, a parameterised-width, SYNC_STAGES-deep synchronizer. It is instantiated for {m2, rw, romsel_n}, addr and data.

Test Plan:
- Reset release while m2_raw=1 held 10 clk, then falls → no strobe; state passes ARM→IDLE. The next normal cycle does strobe.
- Write cycle: addr=0xA000, dat=0x1E, rw=0, M2 high 12 clk → one wr_stb, bus_addr=0xA000, bus_dat=0x1E, 3 clk after the raw fall.
- Read cycle: addr=0x8001, rw=1, romsel_n=0, M2 high 12 clk → one rd_stb, wr_stb stays 0, bus_romsel_n=0.
- M2 glitch of 2 clk high with rw=0 → no strobe, glitch_cnt 0→1. Outputs retain the previous values (0xA000/0x1E).
- M2 held high 300 clk → m2_stuck=1 from clk 256 onward. On fall: m2_stuck=0, no strobe; the next 12-clk write strobes normally.
- Back-to-back writes, M2 high 5 clk / low 1 clk, 4 cycles with data 0x01..0x04 → exactly 4 wr_stb pulses, bus_dat sequence 0x01,0x02,0x03,0x04, none dropped.
